pll_drp_ctrl: RTL and testbench

- DRP initiator that reconfigures a 7-series PLL/MMCM model through its dynamic reconfiguration port (DADDR/DEN/DWE/DI/DO/DRDY).
- Accepts a stream of (address, mask, data) entries and holds the PLL in reset while it applies them.
- Each entry is a read-modify-write: new = (DO & MASK) | (DATA & ~MASK).
- After the last entry it releases the PLL reset, waits for LOCKED, and reports DONE or an error code.

---
 rtl/pll_drp_pkg.sv | 34 +++
 rtl/pll_drp_ctrl_drp_access.sv | 68 ++++++
 rtl/pll_drp_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLL DRP reconfiguration controller.
// The optional readback verify (PLL_DRP_CTRL_READBACK_EN) uses ST_VFY_* and ERR_VERIFY.
package pll_drp_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT_ENTRY,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_VFY_REQ,
        ST_VFY_WAIT,
        ST_RELEASE,
        ST_WAIT_LOCK
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DRDY   = 2'd1;
    localparam logic [1:0] ERR_LOCK   = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    // A set mask bit keeps the current register bit; a clear one takes the new data bit.
    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] mask,
                                                    input logic [DATA_W-1:0] data);
        return (old_val & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/pll_drp_ctrl_drp_access.sv
// Single DRP transaction engine: one-cycle DEN pulse, DRDY wait and timeout.
// DADDR/DI are held between accesses; DRDY is only honoured after the DEN cycle.
module drp_access
    import pll_drp_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_drdy,
    output logic              o_den,
    output logic              o_dwe,
    output logic [ADDR_W-1:0] o_daddr,
    output logic [DATA_W-1:0] o_di,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic              r_den;
    logic              r_dwe;
    logic [ADDR_W-1:0] r_daddr;
    logic [DATA_W-1:0] r_di;
    logic              r_pending;
    logic [CW-1:0]     r_cnt;
    logic              w_wait;

    // NOTE: done/timeout are combinational so the sequencer can react in the DRDY cycle itself.
    assign w_wait    = r_pending & ~r_den;
    assign o_done    = w_wait & i_drdy;
    assign o_timeout = w_wait & ~i_drdy & (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_den     <= 1'b0;
            r_dwe     <= 1'b0;
            r_daddr   <= '0;
            r_di      <= '0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_den <= i_start;
            r_dwe <= i_start & i_we;
            if (i_start) begin
                r_pending <= 1'b1;
                r_cnt     <= '0;
                r_daddr   <= i_addr;
                if (i_we) r_di <= i_wdata;
            end else if (o_done || o_timeout) begin
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_den   = r_den;
    assign o_dwe   = r_dwe;
    assign o_daddr = r_daddr;
    assign o_di    = r_di;

endmodule

// File: rtl/pll_drp_ctrl.sv
// DRP initiator: holds the PLL in reset, applies read-modify-write entries, waits for lock.
// Define PLL_DRP_CTRL_READBACK_EN to add a verify read after every write.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 4
) (
    input  logic              i_dclk,
    input  logic              i_rst,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [DATA_W-1:0] i_cfg_mask,
    input  logic [DATA_W-1:0] i_cfg_data,
    input  logic              i_cfg_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_daddr,
    output logic              o_den,
    output logic              o_dwe,
    output logic [DATA_W-1:0] o_di,
    input  logic [DATA_W-1:0] i_do,
    input  logic              i_drdy,
    output logic              o_pll_rst,
    input  logic              i_locked
);

    localparam int HW = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam int LW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

    state_t            r_state;
    logic              r_cfg_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [1:0]        r_err_code;
    logic              r_pll_rst;
    logic [HW-1:0]     r_hold_cnt;
    logic [LW-1:0]     r_lock_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    logic              w_handshake;
    logic              w_rd_start;
    logic              w_wr_start;
    logic              w_vfy_start;
    logic              w_acc_start;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_acc_done;
    logic              w_acc_timeout;

    assign w_handshake = r_cfg_ready & i_cfg_valid;
    assign w_rd_start  = w_handshake;
    assign w_wr_start  = (r_state == ST_RD_WAIT) & w_acc_done;
`ifdef PLL_DRP_CTRL_READBACK_EN
    assign w_vfy_start = (r_state == ST_WR_WAIT) & w_acc_done;
`else
    assign w_vfy_start = 1'b0;
`endif
    assign w_acc_start = w_rd_start | w_wr_start | w_vfy_start;
    // The read is launched in the handshake cycle, before the entry registers load.
    assign w_acc_addr  = w_rd_start ? i_cfg_addr : r_addr;
    assign w_acc_wdata = rmw_merge(i_do, r_mask, r_data);

    drp_access #(
        .TIMEOUT (DRDY_TIMEOUT)
    ) u_drp_access (
        .i_clk     (i_dclk),
        .i_rst     (i_rst),
        .i_start   (w_acc_start),
        .i_we      (w_wr_start),
        .i_addr    (w_acc_addr),
        .i_wdata   (w_acc_wdata),
        .i_drdy    (i_drdy),
        .o_den     (o_den),
        .o_dwe     (o_dwe),
        .o_daddr   (o_daddr),
        .o_di      (o_di),
        .o_done    (w_acc_done),
        .o_timeout (w_acc_timeout)
    );

    // NOTE: outputs are registered, so each transition sets them for the state it enters.
    always_ff @(posedge i_dclk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_pll_rst   <= 1'b0;
            r_hold_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_addr      <= '0;
            r_mask      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_valid) begin
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                        r_pll_rst  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_cfg_ready <= 1'b1;
                        r_state     <= ST_WAIT_ENTRY;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_WAIT_ENTRY: begin
                    if (w_handshake) begin
                        r_cfg_ready <= 1'b0;
                        r_addr      <= i_cfg_addr;
                        r_mask      <= i_cfg_mask;
                        r_data      <= i_cfg_data;
                        r_last      <= i_cfg_last;
                        r_state     <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (w_acc_done) begin
                        r_state <= ST_WR_REQ;
                    end else if (w_acc_timeout) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WR_REQ: r_state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (w_acc_done) begin
`ifdef PLL_DRP_CTRL_READBACK_EN
                        r_state <= ST_VFY_REQ;
`else
                        if (r_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= ST_RELEASE;
                        end else begin
                            r_cfg_ready <= 1'b1;
                            r_state     <= ST_WAIT_ENTRY;
                        end
`endif
                    end else if (w_acc_timeout) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`ifdef PLL_DRP_CTRL_READBACK_EN
                ST_VFY_REQ: r_state <= ST_VFY_WAIT;
                ST_VFY_WAIT: begin
                    if (w_acc_done) begin
                        if (i_do != o_di) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_VERIFY;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (r_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= ST_RELEASE;
                        end else begin
                            r_cfg_ready <= 1'b1;
                            r_state     <= ST_WAIT_ENTRY;
                        end
                    end else if (w_acc_timeout) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_DRDY;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                // LOCKED is not looked at here: this is the first cycle with the PLL out of reset.
                ST_RELEASE: begin
                    r_lock_cnt <= '0;
                    r_state    <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (i_locked) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_LOCK;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign o_pll_rst   = r_pll_rst;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: behavioural PLL/DRP model plus a transaction-level reference.
// Honours PLL_DRP_CTRL_READBACK_EN for the expected access sequence and verify outcome.
module tb_pll_drp_ctrl;

    localparam int DRDY_TO = 8;
    localparam int LOCK_TO = 20;
    localparam int HOLD    = 4;

    logic        dclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic        cfg_last;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] do_data = 16'h0;
    logic        drdy    = 1'b0;
    logic        pll_rst;
    logic        locked  = 1'b0;

    always #5 dclk = ~dclk;

    pll_drp_ctrl #(
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO),
        .RST_HOLD     (HOLD)
    ) dut (
        .i_dclk      (dclk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_mask  (cfg_mask),
        .i_cfg_data  (cfg_data),
        .i_cfg_last  (cfg_last),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_err_code  (err_code),
        .o_daddr     (daddr),
        .o_den       (den),
        .o_dwe       (dwe),
        .o_di        (di),
        .i_do        (do_data),
        .i_drdy      (drdy),
        .o_pll_rst   (pll_rst),
        .i_locked    (locked)
    );

    typedef struct {
        bit          we;
        logic [6:0]  addr;
        logic [15:0] data;
        int          cyc;
    } acc_t;

    acc_t        log_q[$];
    acc_t        exp_q[$];
    logic [15:0] dev_mem [128];
    bit          dev_wr  [128];
    logic [15:0] ref_mem [128];
    logic [6:0]  e_addr [4];
    logic [15:0] e_mask [4];
    logic [15:0] e_data [4];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int lat_min = 1, lat_max = 4;
    bit never_drdy = 0;
    bit corrupt = 0;
    bit lock_en = 1;
    int lock_dly = 3;
    int m_cnt = 0;
    logic [6:0]  m_addr;
    bit          m_we;
    logic [15:0] m_di;
    int n_drdy = 0;
    int rel_cyc = 0, rel_drdy = 0;
    int viol = 0;
    int lcnt = 0;
    logic prev_pll_rst = 1'b0;

    always @(posedge dclk) cyc++;

    // PLL model: DRP register file with per-access latency, lock after reset release.
    always @(negedge dclk) begin
        acc_t a;
        drdy = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                drdy = 1'b1;
                n_drdy++;
                if (m_we) begin
                    dev_mem[m_addr] = m_di;
                    dev_wr[m_addr]  = 1'b1;
                end else begin
                    do_data = dev_mem[m_addr] ^ {15'd0, corrupt && dev_wr[m_addr]};
                end
            end
        end
        if (den === 1'b1) begin
            if (m_cnt > 0 || pll_rst !== 1'b1) viol++;
            a.we   = dwe;
            a.addr = daddr;
            a.data = dwe ? di : 16'h0;
            a.cyc  = cyc;
            log_q.push_back(a);
            m_cnt  = never_drdy ? 0 : int'($urandom_range(lat_max, lat_min));
            m_addr = daddr;
            m_we   = dwe;
            m_di   = di;
        end
        if (cfg_ready === 1'b1 && (m_cnt > 0 || den || !pll_rst || !busy)) viol++;
        if (prev_pll_rst === 1'b1 && pll_rst === 1'b0) begin
            rel_cyc  = cyc;
            rel_drdy = n_drdy;
        end
        prev_pll_rst = pll_rst;
        if (pll_rst !== 1'b0) begin
            locked = 1'b0;
            lcnt   = 0;
        end else if (lock_en) begin
            lcnt++;
            if (lcnt >= lock_dly) locked = 1'b1;
        end else begin
            locked = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                              input bit last);
        bit got = 0;
        @(negedge dclk);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_mask  = m;
        cfg_data  = d;
        cfg_last  = last;
        for (int t = 0; t < 400 && !got; t++) begin
            if (cfg_ready === 1'b1) begin
                @(posedge dclk);
                got = 1;
            end else begin
                @(negedge dclk);
            end
        end
        #1 cfg_valid = 1'b0;
        check("entry_accepted", 32'(got), 32'd1);
    endtask

    // Reference: each entry reads the address, writes the merged value (and re-reads it).
    task automatic run_job(input int n, input int gap);
        acc_t        a;
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = (ref_mem[e_addr[i]] & e_mask[i]) | (e_data[i] & ~e_mask[i]);
            ref_mem[e_addr[i]] = w;
            a.we = 0; a.addr = e_addr[i]; a.data = 16'h0; a.cyc = 0;
            exp_q.push_back(a);
            a.we = 1; a.data = w;
            exp_q.push_back(a);
`ifdef PLL_DRP_CTRL_READBACK_EN
            a.we = 0; a.data = 16'h0;
            exp_q.push_back(a);
`endif
            send_entry(e_addr[i], e_mask[i], e_data[i], i == n - 1);
            if (i != n - 1) repeat (gap) @(negedge dclk);
        end
    endtask

    task automatic wait_end(input int budget, output bit saw_done, output bit saw_err,
                            output int at_cyc);
        saw_done = 0;
        saw_err  = 0;
        at_cyc   = 0;
        for (int t = 0; t < budget && !saw_done && !saw_err; t++) begin
            @(negedge dclk);
            if (done === 1'b1) saw_done = 1;
            if (error === 1'b1) saw_err = 1;
            at_cyc = cyc;
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_access"}, {8'd0, log_q[i].we, log_q[i].addr, log_q[i].data},
                  {8'd0, exp_q[i].we, exp_q[i].addr, exp_q[i].data});
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {23'd0, cfg_ready, busy, done, error, err_code, den, dwe, pll_rst},
              32'd0);
        check({tag, "_bus"}, {9'd0, daddr, di}, 32'd0);
    endtask

    initial begin
        bit sd, se;
        int at, base, nacc, base_len, den_seen;

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_data = '0; cfg_last = 0;
        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = 16'($urandom);
            ref_mem[i] = dev_mem[i];
            dev_wr[i]  = 0;
        end
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single entry against a known register value.
        dev_mem[8] = 16'hF0F0; ref_mem[8] = 16'hF0F0;
        e_addr[0] = 7'h08; e_mask[0] = 16'h1000; e_data[0] = 16'h0041;
        base = n_drdy;
        run_job(1, 0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_end(200, sd, se, at);
        check("t1_done", 32'(sd), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        @(negedge dclk);
        check("t1_done_width", 32'(done), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_pll_rst_after", 32'(pll_rst), 32'd0);
        if (log_q.size() >= 2) check("t1_di", 32'(log_q[1].data), 32'h1041);
        nacc = log_q.size();
        check("t1_release_after_drdy", 32'(rel_drdy - base), 32'(nacc));
        compare_log("t1");

        // Randomized multi-entry jobs; the first one uses the 5-cycle gap case.
        for (int j = 0; j < 4; j++) begin
            int n   = (j == 0) ? 3 : int'($urandom_range(4, 1));
            int gap = (j == 0) ? 5 : int'($urandom_range(6, 0));
            for (int i = 0; i < n; i++) begin
                e_addr[i] = 7'($urandom_range(127, 0));
                e_mask[i] = 16'($urandom);
                e_data[i] = 16'($urandom);
            end
            base = n_drdy;
            run_job(n, gap);
            wait_end(300, sd, se, at);
            check("t2_done", 32'(sd), 32'd1);
            check("t2_error", 32'(error), 32'd0);
            check("t2_release_after_drdy", 32'(rel_drdy - base), 32'(exp_q.size()));
            compare_log("t2");
            repeat (2) @(negedge dclk);
        end

        // DRDY never returns.
        never_drdy = 1;
        log_q.delete();
        send_entry(7'h11, 16'h00FF, 16'h1234, 1'b1);
        wait_end(100, sd, se, at);
        check("t3_error", 32'(se), 32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        check("t3_len", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) check("t3_delay", 32'(at - log_q[0].cyc), 32'(DRDY_TO));
        check("t3_pll_rst", 32'(pll_rst), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge dclk);
        check("t3_sticky", {30'd0, error, den}, 32'd2);
        never_drdy = 0;
        log_q.delete();

        // LOCKED held low, then a fresh job clears the error.
        lock_en = 0;
        e_addr[0] = 7'h27; e_mask[0] = 16'hA5A5; e_data[0] = 16'h5A5A;
        run_job(1, 0);
        check("t4_error_cleared_on_start", 32'(error), 32'd0);
        wait_end(200, sd, se, at);
        check("t4_error", 32'(se), 32'd1);
        check("t4_code", 32'(err_code), 32'd2);
        // Released in RELEASE; WAIT_LOCK then runs LOCK_TO cycles before the flag shows.
        check("t4_delay", 32'(at - rel_cyc), 32'(LOCK_TO + 1));
        compare_log("t4");
        lock_en = 1;
        e_addr[0] = 7'h28; e_mask[0] = 16'h0000; e_data[0] = 16'hBEEF;
        run_job(1, 0);
        check("t4b_error_cleared", {30'd0, err_code}, 32'd0);
        check("t4b_error_flag", 32'(error), 32'd0);
        wait_end(200, sd, se, at);
        check("t4b_done", 32'(sd), 32'd1);
        compare_log("t4b");

        // Reset during the read wait; the late DRDY must change nothing.
        lat_min = 6; lat_max = 6;
        send_entry(7'h33, 16'h0F0F, 16'hCAFE, 1'b1);
        den_seen = 0;
        for (int t = 0; t < 50 && den_seen == 0; t++) begin
            @(negedge dclk);
            if (den === 1'b1) den_seen = 1;
        end
        check("t5_den_seen", 32'(den_seen), 32'd1);
        @(negedge dclk);
        rst = 1'b1;
        @(negedge dclk);
        rst = 1'b0;
        check_all_zero("t5_after_rst");
        base_len = log_q.size();
        base     = n_drdy;
        den_seen = 0;
        repeat (12) begin
            @(negedge dclk);
            if (den === 1'b1) den_seen++;
        end
        check("t5_no_den", 32'(den_seen), 32'd0);
        check("t5_log", 32'(log_q.size()), 32'(base_len));
        check("t5_late_drdy", 32'(n_drdy - base), 32'd1);
        check_all_zero("t5_idle");
        lat_min = 1; lat_max = 4;
        log_q.delete();

        // Readback corrupted in bit 0.
        corrupt = 1;
        for (int i = 0; i < 128; i++) dev_wr[i] = 0;
        e_addr[0] = 7'h4C; e_mask[0] = 16'hFF00; e_data[0] = 16'h00C3;
        run_job(1, 0);
        wait_end(200, sd, se, at);
`ifdef PLL_DRP_CTRL_READBACK_EN
        check("t6_error", 32'(se), 32'd1);
        check("t6_code", 32'(err_code), 32'd3);
`else
        check("t6_done", 32'(sd), 32'd1);
        check("t6_error", 32'(error), 32'd0);
`endif
        compare_log("t6");
        corrupt = 0;

        check("protocol_violations", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
